// File: rtl/imem_loader.sv
// Instruction-memory loader: takes 32-bit words over a valid/ready stream and
// writes them as little-endian bytes, holding the core in reset until the program is loaded.
module imem_loader #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 512,
  localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       buf_q;
  logic              last_q;
  logic [1:0]        idx_q;
  logic              at_max;

  // Capacity is checked before a word is accepted, so the address never wraps.
  assign at_max = (count_q == MAX_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_ACCEPT;
      S_ACCEPT: begin
        if (at_max)          state_next = S_ERR;
        else if (word_valid) state_next = S_WRITE;
      end
      S_WRITE:  if (idx_q == 2'd3) state_next = last_q ? S_DONE : S_ACCEPT;
      S_DONE:   if (start) state_next = S_ACCEPT;
      S_ERR:    if (start) state_next = S_ACCEPT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= BASE;
      count_q <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            addr_q  <= BASE;
            count_q <= '0;
          end
        end
        S_ACCEPT: begin
          if (word_ready && word_valid) begin
            buf_q  <= word_data;
            last_q <= word_last;
            idx_q  <= '0;
          end
        end
        S_WRITE: begin
          addr_q <= addr_q + 1'b1;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == 2'd3) count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state and registers only; word_valid never reaches word_ready.
  always_comb begin
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    cpu_rst_n  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_ACCEPT: begin
        busy       = 1'b1;
        word_ready = !at_max;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = buf_q[{idx_q, 3'b000} +: 8];
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr   = addr_q;
  assign word_count = count_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Programs the byte-addressed instruction memory before the core runs.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one as four little-endian bytes: byte0 at A, byte1 at A+1, byte2 at A+2, byte3 at A+3.
- This matches the {imem[A+3],imem[A+2],imem[A+1],imem[A]} read assembly.
- Holds the core in reset until a complete program has been loaded.

Parameters:
- ADDR_W, 11, byte-address width of the instruction memory (2048 bytes).
- BASE_ADDR, 0, first byte address written; must be a multiple of 4.
- MAX_WORDS, 512, maximum words per load. Constraint: BASE_ADDR + 4*MAX_WORDS <= 2**ADDR_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle load request.
- word_valid  input  1  word_data/word_last valid.
- word_data  input  32  instruction word.
- word_last  input  1  marks the final word of the program.
- word_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  byte write enable to instruction memory.
- mem_addr  output  ADDR_W  byte write address.
- mem_wdata  output  8  byte write data.
- cpu_rst_n  output  1  active-low reset to the core; high only after a successful load.
- busy  output  1  load in progress.
- done  output  1  load completed successfully.
- error  output  1  MAX_WORDS exceeded without word_last.
- word_count  output  $clog2(MAX_WORDS+1)  words written in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - Outputs: word_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0, word_count=0.
  - Holding registers (word buffer, last flag, byte index) are cleared.
- All outputs are registered or decoded from state. There is no combinational path from word_valid to word_ready.
- IDLE:
  - start=1 -> ACCEPT.
  - Byte address is loaded with BASE_ADDR; word_count is cleared.
- ACCEPT:
  - busy=1.
  - If word_count==MAX_WORDS: go to ERR; word_ready stays 0.
  - Otherwise word_ready=1.
  - On word_valid & word_ready: capture word_data and word_last, set byte index to 0, go to WRITE.
  - word_data is ignored outside a handshake.
- WRITE (four cycles, byte index 0..3):
  - busy=1, mem_we=1, mem_addr=current address, mem_wdata=captured_word[8*idx+7 : 8*idx].
  - Address and index increment each cycle.
  - On idx==3: word_count increments; then go to DONE if the captured last flag is set, else back to ACCEPT.
  - Throughput is 5 cycles per word: 1 handshake cycle plus 4 write cycles.
- DONE:
  - done=1, cpu_rst_n=1, busy=0.
  - Stays in DONE; start=1 -> ACCEPT. This clears done and word_count, forces cpu_rst_n=0, and restarts at BASE_ADDR.
- ERR:
  - error=1, cpu_rst_n=0, busy=0, no writes.
  - start=1 -> ACCEPT, clearing error and word_count.
- start is ignored in ACCEPT and WRITE.
- The address never wraps, because the MAX_WORDS check happens before a word is accepted.
- word_last on the very first word is legal and yields a 1-word program.
- rst asserted mid-WRITE:
  - mem_we drops immediately (asynchronously).
  - Bytes already written stay in memory; no rollback.
  - The next start begins again at BASE_ADDR.

Test Plan:
1. Single word: reset, start, then word 0x00A182B3 with last=1 -> writes (addr,data) = (0,B3),(1,82),(2,A1),(3,00) on 4 consecutive cycles; then done=1, cpu_rst_n=1, word_count=1.
2. Back-to-back stream: 3 words 0x40C88133, 0x015E1D33, 0x00A182B3 with valid held high, last on the third -> word_ready pulses once every 5 cycles; addresses 0..11 written in order; done after byte 11; word_count=3.
3. Stall: word_valid low for 7 cycles in ACCEPT while word_data toggles -> no mem_we, word_ready held 1; next valid word is written at the correct address.
4. Overflow with MAX_WORDS=2: 3 words, none with last -> bytes 0..7 written; then ERR with error=1, word_ready=0, cpu_rst_n=0; third word never acknowledged.
5. Reset mid-load: assert rst during the byte-2 write of word 1 -> mem_we=0 in the same cycle and all outputs at reset values; a new start plus one last word writes at addresses 0..3.
6. Restart from DONE: after scenario 1, pulse start; also pulse start during WRITE -> the start during WRITE is ignored; the start from DONE clears done, drops cpu_rst_n, resets word_count to 0, and a new load begins at BASE_ADDR.
